ysyx_22050133_mem_arb: RTL and testbench

YSYX_22050133_MEM_ARB -- requirements
Module: ysyx_22050133_mem_arb

---
 rtl/ysyx_22050133_mem_arb.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22050133_mem_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_mem_arb.sv
//------------------------------------------------------------------------------
// ysyx_22050133_mem_arb
//
// Arbitrates a single shared memory port between the instruction-fetch (IF)
// and load/store (LS) requesters. At most one transaction is outstanding.
// LS has priority, except that IF is forced through after STARVE_MAX
// consecutive LS grants that happened while IF was waiting.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req_*/if_addr          fetch read request (valid/ready handshake)
//   if_resp_valid/if_rdata    fetch response (single-cycle pulse)
//   ls_req_*/ls_addr/ls_wen/ls_wdata/ls_wmask
//                             load/store request (valid/ready handshake)
//   ls_resp_valid/ls_rdata    load data or store acknowledge (single-cycle)
//   flush                     discard the response of the in-flight IF access
//   mem_req_*/mem_addr/mem_wen/mem_wdata/mem_wmask
//                             shared memory request (valid/ready handshake)
//   mem_resp_valid/mem_rdata  shared memory response
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module ysyx_22050133_mem_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    output logic [63:0] if_rdata,

    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_addr,
    input  logic        ls_wen,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    output logic        ls_resp_valid,
    output logic [63:0] ls_rdata,

    input  logic        flush,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        owner_ls_q;      // 1: LS owns the transaction, 0: IF
    logic [2:0]  starve_q, starve_d;
    logic        drop_q, drop_d;
    logic [63:0] addr_q;
    logic        wen_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;

    logic        ls_win, if_win;

    // IF overrides LS only once it has been passed over STARVE_MAX times.
    always_comb begin
        ls_win = ls_req_valid && !((starve_q == STARVE_LIM) && if_req_valid);
        if_win = if_req_valid && !ls_win;
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        drop_d        = drop_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        if_rdata      = 64'd0;
        ls_rdata      = 64'd0;
        mem_req_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // No handshake is offered while reset is held, so nothing is
                // accepted and then lost.
                if (!rst && (ls_win || if_win)) begin
                    ls_req_ready = ls_win;
                    if_req_ready = if_win;
                    state_d      = ISSUE;
                    if (ls_win && if_req_valid && (starve_q < STARVE_LIM))
                        starve_d = starve_q + 3'd1;
                    else
                        starve_d = 3'd0;
                    drop_d = if_win && flush;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_d = WAIT;
                if (flush && !owner_ls_q)
                    drop_d = 1'b1;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (owner_ls_q) begin
                        ls_resp_valid = 1'b1;
                        ls_rdata      = mem_rdata;
                    end else if (!drop_q && !flush) begin
                        // A flush arriving together with the response also
                        // discards it.
                        if_resp_valid = 1'b1;
                        if_rdata      = mem_rdata;
                    end
                end else if (flush && !owner_ls_q) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_ls_q <= 1'b0;
            starve_q   <= 3'd0;
            drop_q     <= 1'b0;
            addr_q     <= 64'd0;
            wen_q      <= 1'b0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            if (state_q == IDLE) begin
                if (ls_win) begin
                    owner_ls_q <= 1'b1;
                    addr_q     <= ls_addr;
                    wen_q      <= ls_wen;
                    wdata_q    <= ls_wdata;
                    wmask_q    <= ls_wmask;
                end else if (if_win) begin
                    owner_ls_q <= 1'b0;
                    addr_q     <= if_addr;
                    wen_q      <= 1'b0;
                    wdata_q    <= 64'd0;
                    wmask_q    <= 8'd0;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_22050133_mem_arb.sv
`timescale 1ns/1ps
module tb_ysyx_22050133_mem_arb;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        flush;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    ysyx_22050133_mem_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] ifq[$];
    logic [63:0] lsq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    int last_if_resp_cyc = 0;
    int issue_cycles = 0;
    int rdy_delay = 0;
    int resp_delay = 0;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return a ^ 64'hDEAD_BEEF_0000_F00D;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string nm);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic push_if(input logic [63:0] a, input bit expect_resp);
        mq.push_back('{a, 1'b0, 64'd0, 8'd0});
        if (expect_resp) ifq.push_back(mem_model(a));
    endtask

    task automatic push_ls(input logic [63:0] a, input logic w, input logic [63:0] d,
                           input logic [7:0] m, input bit expect_resp);
        mq.push_back('{a, w, d, m});
        if (expect_resp) lsq.push_back(mem_model(a));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory port model: ready after rdy_delay cycles, response resp_delay
    // cycles after the accepting cycle's successor.
    initial begin
        bit          pend = 0;
        int          rd_cnt = 0;
        int          wt_cnt = 0;
        logic [63:0] paddr = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            mem_rdata      = 64'd0;
            mem_req_ready  = 1'b0;
            if (pend) begin
                if (rd_cnt >= resp_delay) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = mem_model(paddr);
                    pend           = 0;
                end else begin
                    rd_cnt++;
                end
            end
            if (!pend && mem_req_valid) begin
                if (wt_cnt >= rdy_delay) begin
                    mem_req_ready = 1'b1;
                    pend          = 1;
                    rd_cnt        = 0;
                    wt_cnt        = 0;
                    paddr         = mem_addr;
                end else begin
                    wt_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mem_req_valid) begin
                issue_cycles++;
                if (mq.size() == 0) begin
                    fail_event("mem_req unexpected request");
                end else begin
                    check("mem_addr",  mem_addr,  mq[0].addr);
                    check("mem_wen",   {63'd0, mem_wen}, {63'd0, mq[0].wen});
                    check("mem_wdata", mem_wdata, mq[0].wdata);
                    check("mem_wmask", {56'd0, mem_wmask}, {56'd0, mq[0].wmask});
                    if (mem_req_ready) begin
                        last_req_cyc = cyc;
                        void'(mq.pop_front());
                    end
                end
            end
            if (if_resp_valid) begin
                last_if_resp_cyc = cyc;
                if (ifq.size() == 0) fail_event("if_resp unexpected response");
                else check("if_rdata", if_rdata, ifq.pop_front());
            end else if (if_rdata != 64'd0) begin
                check("if_rdata_idle", if_rdata, 64'd0);
            end
            if (ls_resp_valid) begin
                if (lsq.size() == 0) fail_event("ls_resp unexpected response");
                else check("ls_rdata", ls_rdata, lsq.pop_front());
            end else if (ls_rdata != 64'd0) begin
                check("ls_rdata_idle", ls_rdata, 64'd0);
            end
        end
    end

    task automatic if_send(input logic [63:0] a, output int gcyc);
        int n = 0;
        if_req_valid = 1'b1;
        if_addr      = a;
        forever begin
            @(negedge clk);
            if (if_req_ready) break;
            n++;
            if (n > 300) begin
                fail_event("if_send handshake timeout");
                break;
            end
        end
        gcyc = cyc;
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        if_addr      = 64'd0;
    endtask

    task automatic ls_send(input logic [63:0] a, input logic w, input logic [63:0] d,
                           input logic [7:0] m);
        int n = 0;
        ls_req_valid = 1'b1;
        ls_addr      = a;
        ls_wen       = w;
        ls_wdata     = d;
        ls_wmask     = m;
        forever begin
            @(negedge clk);
            if (ls_req_ready) break;
            n++;
            if (n > 300) begin
                fail_event("ls_send handshake timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        ls_req_valid = 1'b0;
        ls_addr      = 64'd0;
        ls_wen       = 1'b0;
        ls_wdata     = 64'd0;
        ls_wmask     = 8'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mq.size() != 0 || ifq.size() != 0 || lsq.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) fail_event("wait_idle timeout");
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int base;
        rst = 1'b1;
        if_req_valid = 1'b0; if_addr = 64'd0;
        ls_req_valid = 1'b0; ls_addr = 64'd0; ls_wen = 1'b0; ls_wdata = 64'd0; ls_wmask = 8'd0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst if_req_ready",  {63'd0, if_req_ready},  64'd0);
        check("rst ls_req_ready",  {63'd0, ls_req_ready},  64'd0);
        check("rst mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst if_resp_valid", {63'd0, if_resp_valid}, 64'd0);
        check("rst ls_resp_valid", {63'd0, ls_resp_valid}, 64'd0);
        check("rst mem_addr",      mem_addr,  64'd0);
        check("rst mem_wdata",     mem_wdata, 64'd0);
        check("rst mem_wmask",     {56'd0, mem_wmask}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // IF alone, zero-wait memory: minimum latency.
        push_if(64'h8000_0000, 1);
        if_send(64'h8000_0000, g);
        wait_idle();
        check("latency mem_req at T+1", 64'(last_req_cyc), 64'(g + 1));
        check("latency if_resp at T+2", 64'(last_if_resp_cyc), 64'(g + 2));

        // IF and LS together with counter 0: LS first, then IF.
        push_ls(64'h8000_3000, 1'b0, 64'd0, 8'd0, 1);
        push_if(64'h8000_0040, 1);
        fork
            ls_send(64'h8000_3000, 1'b0, 64'd0, 8'd0);
            if_send(64'h8000_0040, g);
        join
        wait_idle();

        // Continuous LS with IF waiting: 4 LS, 1 IF, repeated.
        for (int i = 0; i < 4; i++) push_ls(64'h8000_2003 + 64'(16 * i), 1'b0, 64'd0, 8'd0, 1);
        push_if(64'h8000_0104, 1);
        for (int i = 4; i < 8; i++) push_ls(64'h8000_2003 + 64'(16 * i), 1'b0, 64'd0, 8'd0, 1);
        push_if(64'h8000_0108, 1);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    ls_send(64'h8000_2003 + 64'(16 * i), 1'b0, 64'd0, 8'd0);
            end
            begin
                int g2;
                if_send(64'h8000_0104, g2);
                if_send(64'h8000_0108, g2);
            end
        join
        wait_idle();

        // Store with memory back-pressure for 3 cycles.
        rdy_delay = 3;
        base = issue_cycles;
        push_ls(64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 1);
        ls_send(64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
        wait_idle();
        check("store issue cycles", 64'(issue_cycles - base), 64'd4);
        rdy_delay = 0;

        // Flush while the IF access waits for its response.
        resp_delay = 2;
        push_if(64'h8000_0200, 0);
        if_send(64'h8000_0200, g);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        push_ls(64'h8000_0300, 1'b0, 64'd0, 8'd0, 1);
        ls_send(64'h8000_0300, 1'b0, 64'd0, 8'd0);
        wait_idle();

        // Flush in the IF grant cycle; then flush during an LS access.
        push_if(64'h8000_0400, 0);
        fork
            begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
            if_send(64'h8000_0400, g);
        join
        push_ls(64'h8000_0500, 1'b1, 64'hCAFE_F00D_1234_5678, 8'hF0, 1);
        ls_send(64'h8000_0500, 1'b1, 64'hCAFE_F00D_1234_5678, 8'hF0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        push_if(64'h8000_0600, 1);
        if_send(64'h8000_0600, g);
        wait_idle();

        // Reset while an LS access waits; its late response must vanish and
        // the starve counter restart from 0 (4 LS before the waiting IF).
        resp_delay = 3;
        push_ls(64'h8000_7000, 1'b0, 64'd0, 8'd0, 1);
        push_ls(64'h8000_7008, 1'b0, 64'd0, 8'd0, 0);
        for (int i = 2; i < 6; i++) push_ls(64'h8000_7000 + 64'(8 * i), 1'b0, 64'd0, 8'd0, 1);
        push_if(64'h8000_0700, 1);
        fork
            if_send(64'h8000_0700, g);
            begin
                for (int i = 0; i < 6; i++)
                    ls_send(64'h8000_7000 + 64'(8 * i), 1'b0, 64'd0, 8'd0);
            end
            begin
                int n = 0;
                forever begin
                    @(negedge clk);
                    if (mem_req_valid && mem_req_ready && mem_addr == 64'h8000_7008) break;
                    n++;
                    if (n > 300) begin
                        fail_event("rst test wait timeout");
                        break;
                    end
                end
                @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("post-rst ls_req_ready", {63'd0, ls_req_ready}, 64'd1);
                check("post-rst if_req_ready", {63'd0, if_req_ready}, 64'd0);
            end
        join
        wait_idle();
        resp_delay = 0;

        check("mem queue drained", 64'(mq.size()),  64'd0);
        check("if queue drained",  64'(ifq.size()), 64'd0);
        check("ls queue drained",  64'(lsq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

endmodule
